// File: rtl/pulse_train_generator.sv
// -----------------------------------------------------------------------------
// pulse_train_generator
//
// Drives a single-bit line with a programmable train of pulses: pulse_count
// pulses, each pulse_width cycles high, separated by gap_len low cycles.
// Settings are captured when start is accepted in IDLE and held for the whole
// train. A zero pulse_width or gap_len is treated as 1. A zero pulse_count
// produces no pulse, only a done strobe. There is no trailing gap after the
// last pulse.
//
// Optional feature (macro PULSE_TRAIN_GENERATOR_ABORT_EN): adds an abort input
// that ends a running train on the next cycle with a done strobe.
//
// Ports:
//   clk          in   clock, all logic on posedge
//   rst          in   synchronous reset, active-high
//   start        in   request a train, sampled only in IDLE
//   abort        in   (optional) end the running train
//   pulse_width  in   high-phase length in cycles
//   gap_len      in   low-phase length in cycles
//   pulse_count  in   number of pulses in the train
//   a            out  generated pulse line, registered
//   busy         out  high while a train is in progress, registered
//   done         out  one-cycle completion strobe, registered
// -----------------------------------------------------------------------------
module pulse_train_generator #(
    parameter int W_WIDTH = 8,
    parameter int W_GAP   = 8,
    parameter int W_COUNT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef PULSE_TRAIN_GENERATOR_ABORT_EN
    input  logic               abort,
`endif
    input  logic [W_WIDTH-1:0] pulse_width,
    input  logic [W_GAP-1:0]   gap_len,
    input  logic [W_COUNT-1:0] pulse_count,
    output logic               a,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_e;

    state_e             state_q, state_d;
    logic [W_WIDTH-1:0] width_q, width_d;
    logic [W_GAP-1:0]   gap_q, gap_d;
    // Cycles remaining in the current phase after the present one.
    logic [W_WIDTH-1:0] high_cnt_q, high_cnt_d;
    logic [W_GAP-1:0]   low_cnt_q, low_cnt_d;
    // Pulses still to come after the one currently (or next) being driven.
    logic [W_COUNT-1:0] left_q, left_d;
    logic               a_q, a_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               abort_req;
    logic [W_WIDTH-1:0] width_eff;
    logic [W_GAP-1:0]   gap_eff;

`ifdef PULSE_TRAIN_GENERATOR_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Zero lengths are promoted to 1 so every phase lasts at least a cycle and
    // consecutive pulses stay separable downstream.
    assign width_eff = (pulse_width == '0) ? W_WIDTH'(1) : pulse_width;
    assign gap_eff   = (gap_len == '0)     ? W_GAP'(1)   : gap_len;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        width_d    = width_q;
        gap_d      = gap_q;
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;
        left_d     = left_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    width_d = width_eff;
                    gap_d   = gap_eff;
                    if (pulse_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = S_HIGH;
                        high_cnt_d = width_eff - W_WIDTH'(1);
                        left_d     = pulse_count - W_COUNT'(1);
                    end
                end
            end
            S_HIGH: begin
                if (abort_req) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (high_cnt_q != '0) begin
                    high_cnt_d = high_cnt_q - W_WIDTH'(1);
                end else if (left_q == '0) begin
                    // Last pulse ends straight into IDLE: no trailing gap.
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d   = S_LOW;
                    low_cnt_d = gap_q - W_GAP'(1);
                end
            end
            S_LOW: begin
                if (abort_req) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (low_cnt_q != '0) begin
                    low_cnt_d = low_cnt_q - W_GAP'(1);
                end else begin
                    state_d    = S_HIGH;
                    high_cnt_d = width_q - W_WIDTH'(1);
                    left_d     = left_q - W_COUNT'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they
        // line up with the state register and have no input-to-output path.
        a_d    = (state_d == S_HIGH);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value, independent of statement order.
        if (rst) begin
            state_q    <= S_IDLE;
            width_q    <= '0;
            gap_q      <= '0;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            left_q     <= '0;
            a_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            gap_q      <= gap_d;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
            left_q     <= left_d;
            a_q        <= a_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign a    = a_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// -----------------------------------------------------------------------------
// tb_pulse_train_generator
//
// Directed trains with hand-written per-cycle waveforms. Each character of a
// waveform string is one cycle, cycle 0 first. The stimulus process drives
// inputs and pushes the expected {a, busy, done} of that cycle into a
// scoreboard queue; a monitor on the falling edge pops and compares.
// Define PULSE_TRAIN_GENERATOR_ABORT_EN to also exercise abort.
// -----------------------------------------------------------------------------
module tb_pulse_train_generator;

    localparam int W_WIDTH = 8;
    localparam int W_GAP   = 8;
    localparam int W_COUNT = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [W_WIDTH-1:0] pulse_width;
    logic [W_GAP-1:0]   gap_len;
    logic [W_COUNT-1:0] pulse_count;
    logic               a;
    logic               busy;
    logic               done;

    pulse_train_generator #(
        .W_WIDTH (W_WIDTH),
        .W_GAP   (W_GAP),
        .W_COUNT (W_COUNT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
`ifdef PULSE_TRAIN_GENERATOR_ABORT_EN
        .abort       (abort),
`endif
        .pulse_width (pulse_width),
        .gap_len     (gap_len),
        .pulse_count (pulse_count),
        .a           (a),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         cyc;
        logic [2:0] exp;   // {a, busy, done}
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input int cyc,
                         input logic [2:0] act, input logic [2:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: {a,busy,done} got %b expected %b",
                     name, cyc, act, exp);
        end
    endtask

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, e.cyc, {a, busy, done}, e.exp);
        end
    end

    function automatic string rep(input string s, input int n);
        string r = "";
        for (int i = 0; i < n; i++) r = {r, s};
        return r;
    endfunction

    function automatic logic bit_at(input string s, input int i);
        return (i < s.len()) && (s[i] == "1");
    endfunction

    // Settings p* apply on cycle 0; alternate settings q* from cycle 1 on,
    // so a mid-train change must not disturb the captured values.
    task automatic apply(input string name,
                         input string st, input string rs, input string ab,
                         input string ea, input string eb, input string ed,
                         input int pw, input int pg, input int pc,
                         input int qw, input int qg, input int qc);
        for (int i = 0; i < ea.len(); i++) begin
            exp_t e;
            start       = bit_at(st, i);
            rst         = bit_at(rs, i);
            abort       = bit_at(ab, i);
            pulse_width = W_WIDTH'((i == 0) ? pw : qw);
            gap_len     = W_GAP'((i == 0) ? pg : qg);
            pulse_count = W_COUNT'((i == 0) ? pc : qc);
            e.name = name;
            e.cyc  = i;
            e.exp  = {bit_at(ea, i), bit_at(eb, i), bit_at(ed, i)};
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst   = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        pulse_width = '0;
        gap_len     = '0;
        pulse_count = '0;
        @(posedge clk);
        #1;

        // Reset held (3 edges in total), then 10 idle cycles.
        apply("reset", "", "11", "",
              "000000000000", "000000000000", "000000000000",
              0, 0, 0, 0, 0, 0);

        apply("w1g2n3", "1000000000", "", "",
              "0100100100", "0111111100", "0000000010",
              1, 2, 3, 1, 2, 3);

        apply("w3g1n2", "1000000000", "", "",
              "0111011100", "0111111100", "0000000010",
              3, 1, 2, 3, 1, 2);

        apply("n0", "1000", "", "",
              "0000", "0000", "0100",
              5, 5, 0, 5, 5, 0);

        apply("w0g0n2", "100000", "", "",
              "010100", "011100", "000010",
              0, 0, 2, 0, 0, 2);

        // Re-start at cycle 2 ignored; start in the done cycle (7) accepted
        // with the alternate settings W1 G1 N1.
        apply("restart", "10100001000", "", "",
              "01100110100", "01111110100", "00000001010",
              2, 2, 2, 1, 1, 1);

        apply("rst_mid", "100000000000", "000100000000", "",
              "011100000000", "011100000000", "000000000000",
              4, 3, 2, 4, 3, 2);

`ifdef PULSE_TRAIN_GENERATOR_ABORT_EN
        apply("abort_mid", "1000000000", "", "0001000000",
              "0111000000", "0111000000", "0000100000",
              4, 3, 2, 4, 3, 2);

        // Abort alone in IDLE is ignored; with start in IDLE, start wins.
        apply("abort_idle", "00100", "", "11100",
              "00010", "00010", "00001",
              1, 1, 1, 1, 1, 1);
`endif

        apply("w_max", {"1", rep("0", 257)}, "", "",
              {"0", rep("1", 255), "00"}, {"0", rep("1", 255), "00"},
              {"0", rep("0", 255), "10"},
              255, 1, 1, 0, 0, 0);

        apply("g_max", {"1", rep("0", 259)}, "", "",
              {"01", rep("0", 255), "100"}, {"0", rep("1", 257), "00"},
              {"0", rep("0", 257), "10"},
              1, 255, 2, 0, 0, 0);

        apply("n_max", {"1", rep("0", 511)}, "", "",
              {"0", rep("10", 254), "100"}, {"0", rep("1", 509), "00"},
              {"0", rep("0", 509), "10"},
              1, 1, 255, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0",
                     sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

endmodule
